// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead adder/subtractor, one lookahead group per stage
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / GROUP;

    // Flat sum-of-products lookahead: every carry is built from g/p terms and the group carry-in.
    function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] g,
                                                   input logic [GROUP-1:0] p,
                                                   input logic             ci);
        logic [GROUP:0] c;
        logic           term;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            term = ci;
            for (int k = 0; k <= i; k++) term = term & p[k];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) term = term & p[k];
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    // lnk_*[k] is what stage k consumes; lnk_*[k+1] is what stage k has registered.
    logic             lnk_vld [STAGES+1];
    logic             lnk_cy  [STAGES+1];
    logic [WIDTH-1:0] lnk_sum [STAGES+1];
    logic [WIDTH-1:0] lnk_a   [STAGES];
    logic [WIDTH-1:0] lnk_b   [STAGES];
    logic             adv;

    assign adv        = !out_valid || out_ready;
    assign in_ready   = adv;

    assign lnk_vld[0] = in_valid;
    assign lnk_cy[0]  = sub | cin;
    assign lnk_sum[0] = '0;
    assign lnk_a[0]   = a;
    assign lnk_b[0]   = b ^ {WIDTH{sub}};

    assign out_valid  = lnk_vld[STAGES];
    assign s          = lnk_sum[STAGES];
    assign cout       = lnk_cy[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             vld_d, vld_q;
        logic             cy_d, cy_q;
        logic [WIDTH-1:0] sum_d, sum_q;

        // Operands and partial sum travel right-shifted so each stage always works on the low group.
        always_comb begin
            g     = lnk_a[k][GROUP-1:0] & lnk_b[k][GROUP-1:0];
            p     = lnk_a[k][GROUP-1:0] ^ lnk_b[k][GROUP-1:0];
            c     = cla_carries(g, p, lnk_cy[k]);
            vld_d = vld_q;
            cy_d  = cy_q;
            sum_d = sum_q;
            if (adv) begin
                vld_d = lnk_vld[k];
                cy_d  = c[GROUP];
                sum_d = lnk_sum[k] >> GROUP;
                sum_d[WIDTH-1 -: GROUP] = p ^ c[GROUP-1:0];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                sum_q <= '0;
            end else begin
                vld_q <= vld_d;
                cy_q  <= cy_d;
                sum_q <= sum_d;
            end
        end

        assign lnk_vld[k+1] = vld_q;
        assign lnk_cy[k+1]  = cy_q;
        assign lnk_sum[k+1] = sum_q;

        if (k < STAGES - 1) begin : g_ops
            logic [WIDTH-1:0] a_d, a_q;
            logic [WIDTH-1:0] b_d, b_q;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                if (adv) begin
                    a_d = lnk_a[k] >> GROUP;
                    b_d = lnk_b[k] >> GROUP;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end

            assign lnk_a[k+1] = a_q;
            assign lnk_b[k+1] = b_q;
        end else begin : g_last
            logic ovf_d, ovf_q;

            always_comb begin
                ovf_d = ovf_q;
                if (adv) ovf_d = c[GROUP] ^ c[GROUP-1];
            end

            always_ff @(posedge clk) begin
                if (rst) ovf_q <= 1'b0;
                else     ovf_q <= ovf_d;
            end

            assign ovf = ovf_q;
        end
    end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - directed and sweep checks of cla_pipe_adder at three parameter sets
module tb_cla_pipe_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        v16 = 0, r16, ov16, or16 = 1, cin16 = 0, sub16 = 0, co16, of16;
    logic [15:0] a16 = 0, b16 = 0, s16;
    logic        v3 = 0, r3, ov3, or3 = 1, cin3 = 0, sub3 = 0, co3, of3;
    logic [2:0]  a3 = 0, b3 = 0, s3;
    logic        v8 = 0, r8, ov8, or8 = 1, cin8 = 0, sub8 = 0, co8, of8;
    logic [7:0]  a8 = 0, b8 = 0, s8;

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .a(a16), .b(b16),
        .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .s(s16),
        .cout(co16), .ovf(of16));
    cla_pipe_adder #(.WIDTH(3), .GROUP(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(r3), .a(a3), .b(b3),
        .cin(cin3), .sub(sub3), .out_valid(ov3), .out_ready(or3), .s(s3),
        .cout(co3), .ovf(of3));
    cla_pipe_adder #(.WIDTH(8), .GROUP(2)) u8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .s(s8),
        .cout(co8), .ovf(of8));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Result packed as {ovf, cout, s[15:0]}.
    function automatic logic [31:0] model(input int w, input logic [15:0] ta, input logic [15:0] tb,
                                          input logic ci, input logic su);
        logic [31:0] mask, be, full, sm;
        logic        c0, co, ov;
        mask = (32'd1 << w) - 32'd1;
        be   = su ? (~{16'd0, tb}) & mask : {16'd0, tb};
        c0   = su ? 1'b1 : ci;
        full = {16'd0, ta} + be + {31'd0, c0};
        sm   = full & mask;
        co   = full[w];
        ov   = (ta[w-1] == be[w-1]) && (sm[w-1] != ta[w-1]);
        return {14'd0, ov, co, sm[15:0]};
    endfunction

    function automatic logic [31:0] obs16();
        return {14'd0, of16, co16, s16};
    endfunction
    function automatic logic [31:0] obs3();
        return {14'd0, of3, co3, 13'd0, s3};
    endfunction
    function automatic logic [31:0] obs8();
        return {14'd0, of8, co8, 8'd0, s8};
    endfunction

    task automatic dir16(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic ts, input logic [31:0] exp);
        int n = 0;
        @(negedge clk);
        a16 = ta; b16 = tb; cin16 = tc; sub16 = ts; v16 = 1; or16 = 1;
        while (n < 20) begin
            @(negedge clk);
            v16 = 0;
            n++;
            if (ov16) break;
        end
        check({tag, "_lat"}, n, 4);
        check(tag, obs16(), exp);
    endtask

    logic [31:0] q16[$];
    logic [31:0] q3[$];
    logic [31:0] q8[$];

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, n3, n8, cyc, sent, got, extra;
        logic        fired;
        logic [31:0] held;

        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        check("rst_out_valid", ov16, 0);
        check("rst_s", s16, 0);
        check("rst_cout", co16, 0);
        check("rst_ovf", of16, 0);
        check("rst_in_ready", r16, 1);

        dir16("carry_all", 16'hFFFF, 16'h0001, 0, 0, 32'h0001_0000);
        dir16("sub_borrow", 16'h0005, 16'h0007, 1, 1, 32'h0000_FFFE);
        dir16("sub_ovf", 16'h8000, 16'h0001, 0, 1, 32'h0003_7FFF);
        dir16("add_ovf", 16'h7FFF, 16'h0001, 0, 0, 32'h0002_8000);
        dir16("add_cin", 16'h1234, 16'h4321, 1, 0, 32'h0000_5556);

        // Latency of the degenerate and the 4-stage narrow configurations.
        @(negedge clk);
        a3 = 3'd7; b3 = 3'd1; cin3 = 0; sub3 = 0; v3 = 1;
        a8 = 8'h7F; b8 = 8'h01; cin8 = 0; sub8 = 0; v8 = 1;
        n = 0; n3 = 0; n8 = 0;
        while ((n3 == 0 || n8 == 0) && n < 20) begin
            @(negedge clk);
            v3 = 0; v8 = 0;
            n++;
            if (ov3 && n3 == 0) begin n3 = n; check("w3_res", obs3(), 32'h0001_0000); end
            if (ov8 && n8 == 0) begin n8 = n; check("w8_res", obs8(), 32'h0002_0080); end
        end
        check("w3_lat", n3, 1);
        check("w8_lat", n8, 4);

        // Back-to-back stream with a 3-cycle output stall.
        sent = 0; got = 0; cyc = 0; fired = 1; held = '0;
        while (got < 10 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (fired) begin
                if (sent < 10) begin
                    a16 = 16'($urandom); b16 = 16'($urandom);
                    cin16 = 1'($urandom); sub16 = 1'($urandom); v16 = 1;
                end else v16 = 0;
            end
            or16 = !(cyc >= 6 && cyc <= 8);
            #1;
            if (!or16) begin
                check("stall_in_ready", r16, 0);
                check("stall_valid", ov16, 1);
                if (cyc == 6) held = obs16();
                else check("stall_hold", obs16(), held);
            end
            if (ov16 && or16) begin
                if (q16.size() == 0) check("stream_extra", 1, 0);
                else check("stream", obs16(), q16.pop_front());
                got++;
            end
            fired = v16 && r16;
            if (fired) begin
                q16.push_back(model(16, a16, b16, cin16, sub16));
                sent++;
            end
        end
        check("stream_count", got, 10);
        v16 = 0; or16 = 1; extra = 0;
        repeat (6) begin @(negedge clk); if (ov16) extra++; end
        check("stream_no_dup", extra, 0);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 0; sub16 = 0; v16 = 1;
        end
        @(negedge clk);
        v16 = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        check("midrst_outputs", {ov16, of16, co16, s16}, 0);
        extra = 0;
        repeat (8) begin @(negedge clk); if (ov16) extra++; end
        check("midrst_no_stale", extra, 0);

        // Exhaustive 3-bit sweep alongside an all-operand 8-bit sweep.
        for (int j = 0; j < 65536 + 8; j++) begin
            @(negedge clk);
            if (j < 65536) begin
                a8 = j[15:8]; b8 = j[7:0]; cin8 = j[0] ^ j[9]; sub8 = j[1] ^ j[8]; v8 = 1;
            end else v8 = 0;
            if (j < 256) begin
                a3 = j[2:0]; b3 = j[5:3]; cin3 = j[6]; sub3 = j[7]; v3 = 1;
            end else v3 = 0;
            #1;
            if (ov8) begin
                if (q8.size() == 0) check("sweep8_extra", 1, 0);
                else check("sweep8", obs8(), q8.pop_front());
            end
            if (ov3) begin
                if (q3.size() == 0) check("sweep3_extra", 1, 0);
                else check("sweep3", obs3(), q3.pop_front());
            end
            if (v8 && r8) q8.push_back(model(8, {8'd0, a8}, {8'd0, b8}, cin8, sub8));
            if (v3 && r3) q3.push_back(model(3, {13'd0, a3}, {13'd0, b3}, cin3, sub3));
        end
        check("sweep8_left", q8.size(), 0);
        check("sweep3_left", q3.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
